// File: rtl/hls_call_arbiter.sv
// hls_call_arbiter: shares one single-issue HLS call/return component between
// two requesters. Grants round-robin, issues one call at a time, routes the
// result back to the issuing requester, and aborts a call whose return never
// arrives, raising a sticky timeout_err.
module hls_call_arbiter #(
    parameter int DATA_W      = 24,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_data,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_data,
    output logic              call_valid,
    input  logic              call_stall,
    output logic [DATA_W-1:0] call_data,
    input  logic              ret_valid,
    output logic              ret_stall,
    input  logic [DATA_W-1:0] ret_data,
    output logic              busy,
    output logic              timeout_err,
    input  logic              clear_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    // Last WAIT count value before the call is abandoned.
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);

    logic [1:0]  state;
    logic        last_grant;
    logic        grant_id;
    logic [15:0] wait_cnt;

    logic        grant_sel;
    logic        accept;
    logic        transfer;
    logic        capture;
    logic        timeout_hit;

    // Round-robin grant decision and handshake qualifiers for this cycle.
    always_comb begin
        grant_sel = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_sel = ~last_grant;
        end else if (req1_valid) begin
            grant_sel = 1'b1;
        end
        // Ready is masked while reset is held so every output reads 0 in reset.
        accept      = reset_n && (state == S_IDLE) && (req0_valid || req1_valid);
        transfer    = (state == S_ISSUE) && !call_stall;
        capture     = ret_valid && (transfer || (state == S_WAIT));
        timeout_hit = (state == S_WAIT) && !ret_valid && (wait_cnt == TIMEOUT_LAST);
    end

    assign req0_ready = accept && !grant_sel;
    assign req1_ready = accept &&  grant_sel;
    assign call_valid = (state == S_ISSUE);
    assign busy       = (state != S_IDLE);
    assign ret_stall  = 1'b0;

    // Call sequencer: IDLE -> ISSUE -> WAIT -> IDLE, with zero-latency and timeout exits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            last_grant <= 1'b1;
            grant_id   <= 1'b0;
            call_data  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        call_data  <= grant_sel ? req1_data : req0_data;
                        grant_id   <= grant_sel;
                        last_grant <= grant_sel;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (transfer) begin
                        state <= capture ? S_IDLE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (capture || timeout_hit) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Return-wait counter: cleared on the call transfer, counts only in WAIT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
        end else if (transfer) begin
            wait_cnt <= '0;
        end else if (state == S_WAIT) begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end

    // Result routing: captured data goes only to the issuing requester, valid pulses once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_data  <= '0;
            rsp1_data  <= '0;
        end else begin
            rsp0_valid <= capture && !grant_id;
            rsp1_valid <= capture &&  grant_id;
            if (capture && !grant_id) begin
                rsp0_data <= ret_data;
            end
            if (capture && grant_id) begin
                rsp1_data <= ret_data;
            end
        end
    end

    // Sticky timeout flag; a new timeout takes priority over a simultaneous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timeout_err <= 1'b0;
        end else if (timeout_hit) begin
            timeout_err <= 1'b1;
        end else if (clear_err) begin
            timeout_err <= 1'b0;
        end
    end

endmodule

// File: doc/hls_call_arbiter.md
Name: hls_call_arbiter

Overview:
- Shares one single-issue HLS component (add-one style call/return streaming interface) between two requesters, e.g. the HPS PIO path (req0) and a KEY-driven local path (req1).
- Arbitrates round-robin and issues one call at a time, then routes the return data back to the requester that issued it.
- Provides a return timeout with a sticky error flag, so a hung component cannot deadlock the display path.

Parameters:
- DATA_W, 24, width of call and return data.
- TIMEOUT_CYC, 1024, cycles allowed in WAIT without ret_valid before abort; legal range 2..65535.

Ports:
- clk  in  1  system clock (CLOCK_50 domain)
- reset_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has a call pending
- req0_data  in  DATA_W  requester 0 argument
- req0_ready  out  1  requester 0 call accepted this cycle
- rsp0_valid  out  1  one-cycle pulse, rsp0_data updated
- rsp0_data  out  DATA_W  last result for requester 0
- req1_valid, req1_data, req1_ready, rsp1_valid, rsp1_data: same as the requester 0 ports, for requester 1
- call_valid  out  1  to component call.valid
- call_stall  in  1  from component call.stall
- call_data  out  DATA_W  to component argument
- ret_valid  in  1  from component return.valid
- ret_stall  out  1  to component return.stall
- ret_data  in  DATA_W  from component returndata
- busy  out  1  high in any state other than IDLE
- timeout_err  out  1  sticky, set on a timeout abort
- clear_err  in  1  synchronous clear of timeout_err

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, last_grant=1 (so req0 wins first).
  - All outputs 0, including rsp*_data, call_data and timeout_err.
  - Reset asserted mid-call aborts the call immediately; no rsp pulse is issued.
- Handshake rules:
  - Component transfers happen on the rising edge where call_valid=1 and call_stall=0.
  - ret_stall is tied 0 in all states, so the component never backs up.
- IDLE:
  - Grant is combinational: if only one reqN_valid is high, grant it. If both are high, grant the one that is not last_grant.
  - reqN_ready=1 combinationally for the granted requester only.
  - On that edge: latch reqN_data into call_data, record grant_id, update last_grant, go to ISSUE.
  - With no requests, stay in IDLE.
- ISSUE:
  - call_valid=1 and call_data held stable while call_stall=1.
  - On the transfer edge go to WAIT and clear the timeout counter.
  - If ret_valid=1 on the same edge as the transfer (zero-latency component), capture the result immediately and go to IDLE; deliver as in WAIT.
  - The timeout counter does not run in ISSUE; a stalled call is held indefinitely.
- WAIT:
  - call_valid=0; the counter increments each cycle.
  - On ret_valid=1: register ret_data into rsp<grant_id>_data and pulse rsp<grant_id>_valid for exactly 1 cycle (the cycle after capture). Go to IDLE.
  - If the counter reaches TIMEOUT_CYC-1 with no ret_valid: set timeout_err, go to IDLE, no rsp pulse, rsp data unchanged.
  - If ret_valid arrives on the timeout cycle, the return wins and no error is flagged.
- ret_valid outside ISSUE-transfer/WAIT: ignored and dropped. This includes late returns after a timeout.
- rspN_data holds its value until the next response to that requester; the other requester's data is never disturbed.
- Latency, with a component that has 1-cycle return and no stall:
  - Edge 0: req accepted.
  - Cycle 1: call_valid high.
  - Cycle 2: ret_valid.
  - Cycle 3: rsp_valid pulse.
  - Next grant possible in cycle 3 (IDLE); maximum throughput is one call per 3 cycles.
- timeout_err: clear_err clears it the next edge. If a set and clear occur together, set wins.
- Requesters must hold reqN_valid/reqN_data until reqN_ready. Deasserting reqN_valid before grant is legal and withdraws the request.

Test Plan:
- Single request: req0_data=24'h000041, component returns arg+1 one cycle after call -> req0_ready at edge 0, call_valid in cycle 1 only, rsp0_valid pulse in cycle 3, rsp0_data=24'h000042; rsp1 signals remain 0.
- Contention: req0 and req1 held high continuously, data 24'h000010/24'h000020 -> grants alternate req0, req1, req0, req1; rsp0_data=24'h000011 and rsp1_data=24'h000021, each delivered to the correct requester.
- Stall: call_stall=1 for 5 cycles after ISSUE entry -> call_valid stays high 6 cycles with call_data constant; busy stays 1; no timeout even with TIMEOUT_CYC=4.
- Timeout: TIMEOUT_CYC=8, component never returns -> return to IDLE 8 cycles after entering WAIT; timeout_err=1; no rsp pulse; a late ret_valid is ignored; clear_err clears the flag; a following call completes normally.
- Zero-latency return: ret_valid=1 on the call transfer edge with ret_data=24'h00FFFF -> rsp0_valid pulse next cycle, rsp0_data=24'h00FFFF, FSM in IDLE.
- Reset mid-WAIT: assert reset_n=0 asynchronously -> all outputs 0 immediately; after release, the first contended grant goes to req0.
